keypad_entry: RTL and testbench

//  Keypad front end for the lock datapath. Collects hex digit key presses into a

---
 rtl/keypad_entry_pkg.sv | 17 +
 rtl/entry_timer.sv | 36 +++
 rtl/keypad_entry.sv | 163 ++++++++++++++++
 tb/tb_keypad_entry.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// rtl/keypad_entry_pkg.sv - shared state encoding and widths for the keypad front end
package keypad_entry_pkg;

    localparam int USER_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2,
        ST_ISSUE   = 2'd3
    } state_e;

    function automatic int code_width(input int digits, input int digit_w);
        return digits * digit_w;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - loadable down-counter with clear and terminal-count pulse
module entry_timer #(
    parameter int LOAD = 4,
    parameter int W    = $clog2(LOAD + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q, cnt_d;

    // A load in the same cycle as clear wins so a fresh entry can restart the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = W'(LOAD);
        else if (clear)
            cnt_d = '0;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    assign tc = en && !load && (cnt_q == W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - collects hex key presses into a code and issues it with an enter strobe
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int DIGIT_W     = 4,
    parameter int TIMEOUT     = 1000,
    parameter int ENTER_PULSE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_code,
    input  logic                          key_enter,
    input  logic                          key_clear,
    input  logic [USER_W-1:0]             user_in,
    input  logic                          alarm_in,
    output logic [DIGITS*DIGIT_W-1:0]     pass_out,
    output logic [USER_W-1:0]             user_out,
    output logic                          enter_out,
    output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
    output logic                          entry_err,
    output logic                          timeout_evt
);

    localparam int CODE_W = code_width(DIGITS, DIGIT_W);
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_buf_q, code_buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   pass_q, pass_d;
    logic [USER_W-1:0]   user_q, user_d;
    logic                enter_q, enter_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic                idle_load, idle_tc, pulse_load, pulse_tc;
    logic                in_entry;

    assign in_entry = (state_q == ST_COLLECT) || (state_q == ST_FULL);

    entry_timer #(.LOAD(TIMEOUT)) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .load  (idle_load),
        .clear (state_q == ST_IDLE),
        .en    (in_entry),
        .tc    (idle_tc)
    );

    entry_timer #(.LOAD(ENTER_PULSE)) u_pulse_timer (
        .clk   (clk),
        .reset (reset),
        .load  (pulse_load),
        .clear (state_q == ST_IDLE),
        .en    (state_q == ST_ISSUE),
        .tc    (pulse_tc)
    );

    always_comb begin
        state_d    = state_q;
        code_buf_d = code_buf_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        user_d     = user_q;
        enter_d    = enter_q;
        err_d      = 1'b0;
        tmo_d      = 1'b0;
        idle_load  = 1'b0;
        pulse_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!alarm_in && !key_clear) begin
                    if (key_enter) begin
                        err_d = 1'b1;
                    end else if (key_valid) begin
                        code_buf_d = CODE_W'(key_code);
                        cnt_d      = CNT_W'(1);
                        idle_load  = 1'b1;
                        state_d    = (DIGITS == 1) ? ST_FULL : ST_COLLECT;
                    end
                end
            end
            ST_COLLECT, ST_FULL: begin
                if (alarm_in || key_clear) begin
                    code_buf_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else if (key_enter) begin
                    if (state_q == ST_FULL) begin
                        pass_d     = code_buf_q;
                        user_d     = user_in;
                        enter_d    = 1'b1;
                        pulse_load = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        err_d      = 1'b1;
                        code_buf_d = '0;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end
                end else if (key_valid) begin
                    idle_load = 1'b1;
                    if (state_q == ST_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        code_buf_d = (code_buf_q << DIGIT_W) | CODE_W'(key_code);
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST)
                            state_d = ST_FULL;
                    end
                end else if (idle_tc) begin
                    tmo_d      = 1'b1;
                    code_buf_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The buffer stays full while the strobe runs; it empties on the last pulse cycle.
                if (pulse_tc) begin
                    enter_d    = 1'b0;
                    code_buf_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            code_buf_q <= '0;
            cnt_q      <= '0;
            pass_q     <= '0;
            user_q     <= '0;
            enter_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_buf_q <= code_buf_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            user_q     <= user_d;
            enter_q    <= enter_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign pass_out    = pass_q;
    assign user_out    = user_q;
    assign enter_out   = enter_q;
    assign digit_cnt   = cnt_q;
    assign entry_err   = err_q;
    assign timeout_evt = tmo_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry against a digit-queue reference model
module tb_keypad_entry;

    localparam int DIGITS      = 3;
    localparam int TIMEOUT     = 1000;
    localparam int ENTER_PULSE = 4;

    localparam int EV_ERR   = 0;
    localparam int EV_TMO   = 1;
    localparam int EV_ISSUE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid, key_enter, key_clear, alarm_in;
    logic [3:0]  key_code;
    logic [1:0]  user_in;
    logic [11:0] pass_out;
    logic [1:0]  user_out;
    logic        enter_out, entry_err, timeout_evt;
    logic [1:0]  digit_cnt;

    keypad_entry #(
        .DIGITS(DIGITS), .DIGIT_W(4), .TIMEOUT(TIMEOUT), .ENTER_PULSE(ENTER_PULSE)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_enter(key_enter), .key_clear(key_clear), .user_in(user_in),
        .alarm_in(alarm_in), .pass_out(pass_out), .user_out(user_out),
        .enter_out(enter_out), .digit_cnt(digit_cnt), .entry_err(entry_err),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [11:0] pass;
        logic [1:0]  user;
    } ev_t;

    ev_t         ev_q[$];
    int          digits[$];
    int          issue_left = 0;
    int          idle_cnt   = 0;
    int          exp_cnt    = 0;
    logic        exp_enter  = 1'b0;
    logic [11:0] exp_pass   = '0;
    logic [1:0]  exp_user   = '0;
    logic        mon_en     = 1'b0;
    logic        prev_enter = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] code_of();
        logic [11:0] r = '0;
        foreach (digits[i]) r = r * 12'd16 + 12'(digits[i]);
        return r;
    endfunction

    task automatic push_ev(input int kind, input logic [11:0] p, input logic [1:0] u);
        ev_t e;
        e.kind = kind; e.pass = p; e.user = u;
        ev_q.push_back(e);
    endtask

    // Reference: a queue of entered digits plus counters for the strobe and idle time.
    task automatic model_cycle(input logic v, input logic [3:0] c, input logic e,
                               input logic cl, input logic [1:0] u, input logic a);
        if (issue_left > 0) begin
            issue_left--;
            if (issue_left == 0) digits.delete();
        end else if (a) begin
            digits.delete();
        end else if (digits.size() == 0) begin
            if (!cl) begin
                if (e) push_ev(EV_ERR, '0, '0);
                else if (v) begin digits.push_back(int'(c)); idle_cnt = 0; end
            end
        end else begin
            if (cl) digits.delete();
            else if (e) begin
                if (digits.size() == DIGITS) begin
                    exp_pass = code_of();
                    exp_user = u;
                    push_ev(EV_ISSUE, exp_pass, u);
                    issue_left = ENTER_PULSE;
                end else begin
                    push_ev(EV_ERR, '0, '0);
                    digits.delete();
                end
            end else if (v) begin
                if (digits.size() == DIGITS) push_ev(EV_ERR, '0, '0);
                else digits.push_back(int'(c));
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    push_ev(EV_TMO, '0, '0);
                    digits.delete();
                end
            end
        end
        exp_cnt   = digits.size();
        exp_enter = (issue_left > 0);
    endtask

    task automatic step(input logic v, input logic [3:0] c, input logic e,
                        input logic cl, input logic [1:0] u, input logic a);
        key_valid = v; key_code = c; key_enter = e; key_clear = cl;
        user_in = u; alarm_in = a;
        @(posedge clk);
        model_cycle(v, c, e, cl, u, a);
        @(negedge clk);
        key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, user_in, alarm_in);
    endtask

    task automatic enter(input logic [1:0] u);
        step(1'b0, 4'h0, 1'b1, 1'b0, u, alarm_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, user_in, alarm_in);
    endtask

    task automatic pop_expect(input int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFF);
        end else begin
            e = ev_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_ISSUE && e.kind == EV_ISSUE) begin
                chk("issue_pass", 32'(pass_out), 32'(e.pass));
                chk("issue_user", 32'(user_out), 32'(e.user));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("digit_cnt", 32'(digit_cnt), 32'(exp_cnt));
            chk("enter_out", 32'(enter_out), 32'(exp_enter));
            chk("pass_out", 32'(pass_out), 32'(exp_pass));
            chk("user_out", 32'(user_out), 32'(exp_user));
            if (entry_err)   pop_expect(EV_ERR);
            if (timeout_evt) pop_expect(EV_TMO);
            if (enter_out && !prev_enter) pop_expect(EV_ISSUE);
            prev_enter = enter_out;
        end
    end

    initial begin
        logic alarm_r;
        int   r;
        reset = 1'b0;
        key_valid = 1'b0; key_code = '0; key_enter = 1'b0; key_clear = 1'b0;
        user_in = '0; alarm_in = 1'b0;
        #12;
        chk("rst_pass", 32'(pass_out), 32'h0);
        chk("rst_enter", 32'(enter_out), 32'h0);
        chk("rst_cnt", 32'(digit_cnt), 32'h0);
        chk("rst_err", 32'(entry_err), 32'h0);
        chk("rst_tmo", 32'(timeout_evt), 32'h0);
        chk("rst_user", 32'(user_out), 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        press(4'h1); press(4'h1); press(4'h1); enter(2'd3); idle(6);
        chk("t1_pass", 32'(pass_out), 32'h111);
        chk("t1_user", 32'(user_out), 32'd3);
        chk("t1_cnt", 32'(digit_cnt), 32'd0);

        press(4'hF); press(4'h1); press(4'hA); enter(2'd1); idle(6);
        press(4'h0); press(4'hA); enter(2'd2); idle(3);
        chk("t2_pass_held", 32'(pass_out), 32'hF1A);

        press(4'h9); press(4'h9); press(4'h9); press(4'h8);
        chk("t3_cnt_sat", 32'(digit_cnt), 32'd3);
        enter(2'd0); idle(6);
        chk("t3_pass", 32'(pass_out), 32'h999);

        press(4'h1); idle(TIMEOUT);
        chk("t4_cnt", 32'(digit_cnt), 32'd0);
        enter(2'd0); idle(2);

        alarm_in = 1'b1;
        press(4'h1); press(4'h8); idle(2);
        chk("t5_cnt_alarm", 32'(digit_cnt), 32'd0);
        alarm_in = 1'b0;
        idle(1);
        press(4'h1); press(4'h8); press(4'h8); enter(2'd2); idle(6);
        chk("t5_pass", 32'(pass_out), 32'h188);

        press(4'h3); press(4'h4); press(4'h5); enter(2'd1); idle(1);
        #2 reset = 1'b0;
        #1;
        chk("t6_enter_async", 32'(enter_out), 32'h0);
        chk("t6_pass_async", 32'(pass_out), 32'h0);
        digits.delete(); issue_left = 0; exp_cnt = 0; exp_enter = 1'b0;
        exp_pass = '0; exp_user = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        press(4'h0); press(4'h0); press(4'h1); enter(2'd0); idle(6);
        chk("t6_pass", 32'(pass_out), 32'h001);

        alarm_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) alarm_r = ~alarm_r;
            r = int'($urandom_range(0, 99));
            step(r < 30 || (r >= 41 && r < 45), 4'($urandom_range(0, 15)),
                 (r >= 30 && r < 38) || (r >= 41 && r < 45), (r >= 38 && r < 41),
                 2'($urandom_range(0, 3)), alarm_r);
        end
        alarm_in = 1'b0;
        idle(10);
        chk("events_drained", 32'(ev_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
